// File: rtl/csr_bank.sv
// csr_bank: parametrised config/status register bank behind a valid/ready request/response port
// with masked config writes, write pulses, optional status synchroniser and sticky W1C interrupt registers.
module csr_bank #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CONFIG_REG = 12,
    parameter int NUM_STATUS_REG = 4,
    parameter logic [DATA_WIDTH*NUM_CONFIG_REG-1:0] CONFIG_RESET = '0,
    parameter logic [DATA_WIDTH*NUM_CONFIG_REG-1:0] WRITE_MASK = '1,
    parameter int STATUS_SYNC = 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   req_valid_i,
    output logic                                   req_ready_o,
    input  logic                                   req_write_i,
    input  logic [ADDR_WIDTH-1:0]                  req_addr_i,
    input  logic [DATA_WIDTH-1:0]                  req_wdata_i,
    output logic                                   rsp_valid_o,
    input  logic                                   rsp_ready_i,
    output logic [DATA_WIDTH-1:0]                  rsp_rdata_o,
    output logic                                   rsp_err_o,
    output logic [DATA_WIDTH*NUM_CONFIG_REG-1:0]   config_bus_o,
    output logic [NUM_CONFIG_REG-1:0]              config_wr_pulse_o,
    input  logic [DATA_WIDTH*NUM_STATUS_REG-1:0]   status_bus_i,
    output logic                                   irq_o
);
    localparam int DW = DATA_WIDTH;
    localparam int NC = NUM_CONFIG_REG;
    localparam int NS = NUM_STATUS_REG;
    localparam int SW = DW * NS;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t               state_q, state_d;
    logic                 wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic [DW*NC-1:0]     cfg_q, cfg_d;
    logic [SW-1:0]        sticky_q, sticky_d;
    logic [NC-1:0]        pulse_q, pulse_d;
    logic [DW-1:0]        rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 irq_q;
    logic [SW-1:0]        status_s;

    generate
        if (STATUS_SYNC != 0) begin : g_sync
            logic [SW-1:0] s0_q, s1_q;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    s0_q <= '0;
                    s1_q <= '0;
                end else begin
                    s0_q <= status_bus_i;
                    s1_q <= s0_q;
                end
            end
            assign status_s = s1_q;
        end else begin : g_nosync
            assign status_s = status_bus_i;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cfg_d    = cfg_q;
        sticky_d = sticky_q | status_s;
        pulse_d  = '0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    wr_d    = req_write_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
                // Unmapped is the fallback; any matching decode below overrides it.
                rdata_d = wr_q ? '0 : '1;
                err_d   = 1'b1;
                for (int i = 0; i < NC; i++) begin
                    if (addr_q == ADDR_WIDTH'(i)) begin
                        err_d = 1'b0;
                        if (wr_q) begin
                            cfg_d[i*DW +: DW] = (cfg_q[i*DW +: DW] & ~WRITE_MASK[i*DW +: DW]) |
                                                (wdata_q & WRITE_MASK[i*DW +: DW]);
                            pulse_d[i] = 1'b1;
                        end else begin
                            rdata_d = cfg_q[i*DW +: DW];
                        end
                    end
                end
                for (int j = 0; j < NS; j++) begin
                    if (addr_q == ADDR_WIDTH'(NC + j)) begin
                        err_d = wr_q;
                        if (!wr_q) rdata_d = status_s[j*DW +: DW];
                    end
                    if (addr_q == ADDR_WIDTH'(NC + NS + j)) begin
                        err_d = 1'b0;
                        if (wr_q) sticky_d[j*DW +: DW] = (sticky_q[j*DW +: DW] & ~wdata_q) | status_s[j*DW +: DW];
                        else rdata_d = sticky_q[j*DW +: DW];
                    end
                end
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cfg_q    <= CONFIG_RESET;
            sticky_q <= '0;
            pulse_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cfg_q    <= cfg_d;
            sticky_q <= sticky_d;
            pulse_q  <= pulse_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            irq_q    <= |sticky_q;
        end
    end

    assign req_ready_o       = state_q == IDLE;
    assign rsp_valid_o       = state_q == RESP;
    assign rsp_rdata_o       = rdata_q;
    assign rsp_err_o         = err_q;
    assign config_bus_o      = cfg_q;
    assign config_wr_pulse_o = pulse_q;
    assign irq_o             = irq_q;
endmodule
